// File: rtl/wb_tlc_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : wb_tlc_pkg
// Description : Shared definitions for the config-request event crossing:
//               FSM state encoding and legal parameter ranges.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_tlc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam int c_SYNC_STAGES_MIN = 2;
  localparam int c_SYNC_STAGES_MAX = 4;
  localparam int c_GAP_MIN         = 0;
  localparam int c_GAP_MAX         = 15;
  localparam int c_GAP_W           = 4;

endpackage
`default_nettype wire

// File: rtl/wb_tlc_cr_tx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : wb_tlc_cr_tx_if
// Description : Event / toggle-handshake / status bundle of the config-request
//               transmitter. slave = transmitter side, master = its user.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_tlc_cr_tx_if #(
  parameter int CNT_W = 4
);
  logic             cr_125;
  logic             cr_req;
  logic             cr_ack_async;
  logic [CNT_W-1:0] cr_pend;
  logic             cr_busy;
  logic             cr_ovf;

  modport master (
    output cr_125, cr_ack_async,
    input  cr_req, cr_pend, cr_busy, cr_ovf
  );

  modport slave (
    input  cr_125, cr_ack_async,
    output cr_req, cr_pend, cr_busy, cr_ovf
  );
endinterface
`default_nettype wire

// File: rtl/wb_tlc_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : wb_tlc_sync
// Description : N-stage flop synchronizer for a single asynchronous bit,
//               synchronous active-high reset. Shared by both crossing ends.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_tlc_sync #(
  parameter int STAGES = 2
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  input  wire logic d_i,
  output logic      q_o
);
  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/wb_tlc_cr_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : wb_tlc_cr_tx
// Description : Transmit end of the config-request crossing. Queues event
//               pulses in a saturating counter and forwards each one as an
//               edge of a 2-phase toggle request, waiting for the toggle ack.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_tlc_cr_tx
  import wb_tlc_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int GAP         = 2
) (
  input  wire logic        clk_125,
  input  wire logic        rst,
  wb_tlc_cr_tx_if.slave    bus
);
  // Out-of-range parameters are clamped to the nearest legal value.
  localparam int c_SYNC_N = (SYNC_STAGES < c_SYNC_STAGES_MIN) ? c_SYNC_STAGES_MIN :
                            (SYNC_STAGES > c_SYNC_STAGES_MAX) ? c_SYNC_STAGES_MAX : SYNC_STAGES;
  localparam int c_GAP_N  = (GAP < c_GAP_MIN) ? c_GAP_MIN :
                            (GAP > c_GAP_MAX) ? c_GAP_MAX : GAP;
  localparam logic [CNT_W-1:0]   c_PEND_MAX = '1;
  // Gap counter is loaded with GAP-1 so the GAP state lasts exactly GAP cycles.
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = (c_GAP_N == 0) ? '0 : c_GAP_W'(c_GAP_N - 1);

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic [c_GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               ovf_q, ovf_d;

  logic w_ack_s;
  logic w_ack_done;
  logic w_full;
  logic w_inc;
  logic w_dec;
  logic w_drop;

  wb_tlc_sync #(.STAGES(c_SYNC_N)) u_ack_sync (
    .clk_i (clk_125),
    .rst_i (rst),
    .d_i   (bus.cr_ack_async),
    .q_o   (w_ack_s)
  );

  // The far end echoes the request level once it has taken the event.
  assign w_ack_done = (state_q == S_WAIT) && (w_ack_s == req_q);
  assign w_full     = (pend_q == c_PEND_MAX);
  assign w_dec      = w_ack_done;
  // A pulse at saturation is still accepted if a slot frees on the same edge.
  assign w_inc      = bus.cr_125 && (!w_full || w_dec);
  assign w_drop     = bus.cr_125 && w_full && !w_dec;

  // Pending counter and sticky overflow next-state.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q | w_drop;
    case ({w_inc, w_dec})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
  end

  // Transfer FSM next-state: one request in flight, then an idle gap.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          req_d   = ~req_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_ack_done) begin
          gap_d   = c_GAP_LOAD;
          state_d = (c_GAP_N == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // All transmitter state registers.
  always_ff @(posedge clk_125) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      gap_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.cr_req  = req_q;
  assign bus.cr_pend = pend_q;
  assign bus.cr_busy = busy_q;
  assign bus.cr_ovf  = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_tlc_cr_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_wb_tlc_cr_tx
// Description : Testbench for wb_tlc_cr_tx with a far-end ack model and a
//               request-toggle scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_tlc_cr_tx;
  localparam int c_ACK_DLY = 5;

  logic clk_125 = 1'b0;
  logic rst     = 1'b1;

  wb_tlc_cr_tx_if #(.CNT_W(4)) bus ();

  wb_tlc_cr_tx #(.CNT_W(4), .SYNC_STAGES(2), .GAP(2)) dut (
    .clk_125 (clk_125),
    .rst     (rst),
    .bus     (bus)
  );

  always #4 clk_125 = ~clk_125;

  int   total    = 0;
  int   bad      = 0;
  int   tog_seen = 0;
  int   ack_tog  = 0;
  int   ack_cyc  = 0;
  int   ack_cnt  = 0;
  int   cyc      = 0;
  bit   ack_en   = 1'b0;
  logic exp_req  = 1'b0;
  logic prev_req = 1'b0;
  logic rst_at_edge = 1'b1;
  logic exp_q[$];

  always @(posedge clk_125) begin
    rst_at_edge <= rst;
    cyc         <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every cr_req toggle must match the next queued event.
  initial forever begin
    @(negedge clk_125);
    if (rst_at_edge) begin
      prev_req = bus.cr_req;
    end else if (bus.cr_req !== prev_req) begin
      prev_req = bus.cr_req;
      tog_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL req_unexpected: got toggle to %0b expected no toggle", bus.cr_req);
      end else begin
        chk("req_toggle", {31'd0, bus.cr_req}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  // Far-end model: echo cr_req onto the ack c_ACK_DLY cycles after seeing it.
  initial forever begin
    @(negedge clk_125);
    if (rst_at_edge) begin
      bus.cr_ack_async = 1'b0;
      ack_cnt = 0;
    end else if (ack_en && (bus.cr_ack_async !== bus.cr_req)) begin
      if (ack_cnt >= c_ACK_DLY) begin
        bus.cr_ack_async = bus.cr_req;
        ack_cnt = 0;
        ack_tog++;
        ack_cyc = cyc;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  task automatic pulses(input int n, input int npush);
    for (int i = 0; i < n; i++) begin
      if (i < npush) begin
        exp_req = ~exp_req;
        exp_q.push_back(exp_req);
      end
      bus.cr_125 = 1'b1;
      @(negedge clk_125);
    end
    bus.cr_125 = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (!(bus.cr_busy === 1'b0 && bus.cr_pend === 4'd0 && exp_q.size() == 0) && n < bound) begin
      @(negedge clk_125);
      n++;
    end
    total++;
    if (n >= bound) begin
      bad++;
      $display("FAIL %s: busy=%0b pend=%0d queued=%0d, expected idle with empty queue",
               name, bus.cr_busy, bus.cr_pend, exp_q.size());
    end
  endtask

  initial begin
    int t0;
    int n;
    bus.cr_125 = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk_125);
    chk("reset_req",  {31'd0, bus.cr_req},  0);
    chk("reset_pend", {28'd0, bus.cr_pend}, 0);
    chk("reset_busy", {31'd0, bus.cr_busy}, 0);
    chk("reset_ovf",  {31'd0, bus.cr_ovf},  0);
    rst = 1'b0;
    ack_en = 1'b1;
    @(negedge clk_125);

    // Single event: 2-cycle request latency, then GAP cycles of busy after ack.
    pulses(1, 1);
    chk("single_pend", {28'd0, bus.cr_pend}, 1);
    chk("single_req_early", {31'd0, bus.cr_req}, 0);
    @(negedge clk_125);
    chk("single_req_latency", {31'd0, bus.cr_req}, 1);
    chk("single_busy", {31'd0, bus.cr_busy}, 1);
    n = 0;
    while (bus.cr_pend !== 4'd0 && n < 100) begin
      @(negedge clk_125);
      n++;
    end
    chk("single_ack_timeout", (n < 100) ? 1 : 0, 1);
    chk("single_gap_busy0", {31'd0, bus.cr_busy}, 1);
    @(negedge clk_125);
    chk("single_gap_busy1", {31'd0, bus.cr_busy}, 1);
    @(negedge clk_125);
    chk("single_idle_busy", {31'd0, bus.cr_busy}, 0);

    // Burst of 6 back-to-back events.
    t0 = tog_seen;
    pulses(6, 6);
    chk("burst_pend", {28'd0, bus.cr_pend}, 6);
    wait_idle(500, "burst_drain");
    chk("burst_toggles", tog_seen - t0, 6);
    chk("burst_ovf", {31'd0, bus.cr_ovf}, 0);

    // Saturation with acks held off.
    ack_en = 1'b0;
    t0 = tog_seen;
    pulses(15, 15);
    chk("sat_pend_full", {28'd0, bus.cr_pend}, 15);
    chk("sat_ovf_clear", {31'd0, bus.cr_ovf}, 0);
    pulses(2, 0);
    chk("sat_pend_held", {28'd0, bus.cr_pend}, 15);
    chk("sat_ovf_set", {31'd0, bus.cr_ovf}, 1);
    ack_en = 1'b1;
    wait_idle(1000, "sat_drain");
    chk("sat_toggles", tog_seen - t0, 15);
    chk("sat_ovf_sticky", {31'd0, bus.cr_ovf}, 1);
    rst = 1'b1;
    @(negedge clk_125);
    chk("sat_ovf_reset", {31'd0, bus.cr_ovf}, 0);
    rst = 1'b0;
    exp_req = 1'b0;
    @(negedge clk_125);

    // Pulse lands on the very edge the ack completes: count unchanged.
    t0 = tog_seen;
    pulses(3, 3);
    chk("simul_pend_pre", {28'd0, bus.cr_pend}, 3);
    n = ack_tog;
    begin
      int k = 0;
      while (!(ack_tog != n && cyc == ack_cyc + 2) && k < 200) begin
        @(negedge clk_125);
        k++;
      end
      chk("simul_ack_timeout", (k < 200) ? 1 : 0, 1);
    end
    chk("simul_pend_before_edge", {28'd0, bus.cr_pend}, 3);
    exp_req = ~exp_req;
    exp_q.push_back(exp_req);
    bus.cr_125 = 1'b1;
    @(negedge clk_125);
    bus.cr_125 = 1'b0;
    chk("simul_pend_after_edge", {28'd0, bus.cr_pend}, 3);
    wait_idle(500, "simul_drain");
    chk("simul_toggles", tog_seen - t0, 4);

    // Reset in the middle of a WAIT.
    ack_en = 1'b0;
    pulses(4, 1);
    chk("rstwait_pend", {28'd0, bus.cr_pend}, 4);
    chk("rstwait_req", {31'd0, bus.cr_req}, 1);
    rst = 1'b1;
    @(negedge clk_125);
    chk("rstwait_req_clr",  {31'd0, bus.cr_req},  0);
    chk("rstwait_pend_clr", {28'd0, bus.cr_pend}, 0);
    chk("rstwait_busy_clr", {31'd0, bus.cr_busy}, 0);
    rst = 1'b0;
    exp_req = 1'b0;
    ack_en = 1'b1;
    @(negedge clk_125);
    pulses(1, 1);
    @(negedge clk_125);
    chk("restart_req", {31'd0, bus.cr_req}, 1);
    wait_idle(200, "restart_drain");
    chk("restart_ovf", {31'd0, bus.cr_ovf}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
